// File: rtl/melody_player_if.sv
// melody_player_if
//   Groups the control and note signals exchanged between the auto-play
//   sequencer and whatever drives it (keypad mux / top level / bench).
//   Ports (as seen from the slave, i.e. the sequencer):
//     play, stop  in   debounced button levels
//     sel         out  one-hot note to buzzer, 0 = silent
//     flat        out  sharp/flat select
//     octave      out  0 = low, 1 = high
//     busy        out  high while a song is playing (NOTE or GAP)
//     done        out  one-cycle pulse at natural song end
//     note_idx    out  index of the current table entry
interface melody_player_if #(
  parameter int IDX_W = 5
);
  logic             play;
  logic             stop;
  logic [6:0]       sel;
  logic             flat;
  logic             octave;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] note_idx;

  modport master (
    output play, stop,
    input  sel, flat, octave, busy, done, note_idx
  );

  modport slave (
    input  play, stop,
    output sel, flat, octave, busy, done, note_idx
  );
endinterface

// File: rtl/melody_player.sv
// melody_player
//   Auto-play sequencer feeding the piano buzzer tone generator. Walks a
//   constant note table, holds each note for dur beats, then inserts a
//   silent gap before the next entry.
//   Ports:
//     clk_1MHz  in   system clock (1 MHz)
//     rst       in   asynchronous, active-low reset
//     bus       melody_player_if.slave: play/stop in; sel, flat, octave,
//               busy, done, note_idx out (all registered)
//   Parameters:
//     TICK_DIV  clock cycles per beat
//     GAP_CYC   silent cycles after every note
//     IDX_W     note-index width, table depth 2**IDX_W
//     TABLE_ID  0 = the song, 1 = end-free diagnostic table
//   Build option:
//     MELODY_LOOP_EN  when defined, the song loops forever (done still
//                     pulses at each wrap); only stop or reset exits.
module melody_player #(
  parameter int TICK_DIV = 125000,
  parameter int GAP_CYC  = 20000,
  parameter int IDX_W    = 5,
  parameter int TABLE_ID = 0
) (
  input  logic          clk_1MHz,
  input  logic          rst,
  melody_player_if.slave bus
);

  localparam int CYC_W_T = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CYC_W_G = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int CYC_W   = (CYC_W_T > CYC_W_G) ? CYC_W_T : CYC_W_G;
  localparam logic [CYC_W-1:0] TICK_LAST = CYC_W'(TICK_DIV - 1);
  localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  // Table entry layout; 'last' is the end-of-song marker.
  typedef struct packed {
    logic       last;
    logic       octave;
    logic       flat;
    logic [2:0] dur;
    logic [2:0] note;
  } entry_t;

  // Constant note table. Unlisted song indices decode to a bare end marker.
  // The diagnostic table is deliberately end-free so a run exercises the
  // index-limit termination.
  function automatic entry_t lookup(input logic [IDX_W-1:0] idx);
    logic [8:0] raw;
    if (TABLE_ID == 0) begin
      case (int'(idx))
        0:       raw = 9'b0_0_0_010_001;  // do, 2 beats
        1:       raw = 9'b0_0_1_001_001;  // do with flat requested, 1 beat
        2:       raw = 9'b1_1_1_000_010;  // high re flat, 8 beats, last
        default: raw = 9'b1_0_0_000_000;
      endcase
    end else begin
      case (int'(idx))
        0:       raw = 9'b0_0_0_001_111;  // ti, 1 beat
        31:      raw = 9'b0_0_0_001_101;  // so, 1 beat
        default: raw = 9'b0_0_0_001_000;  // rest, 1 beat
      endcase
    end
    lookup = entry_t'(raw);
  endfunction

  function automatic logic [6:0] note_sel(input logic [2:0] note);
    note_sel = (note == 3'd0) ? 7'd0 : (7'b1000000 >> (note - 3'd1));
  endfunction

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       beat_q, beat_d;
  logic [IDX_W-1:0] note_idx_q, note_idx_d;
  logic [6:0]       sel_q, sel_d;
  logic             flat_q, flat_d;
  logic             octave_q, octave_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             play_q, stop_q;

  entry_t           cur_entry, load_entry;
  logic [IDX_W-1:0] load_idx;
  logic [3:0]       dur_beats;
  logic             play_e, stop_e, note_done, gap_done, song_end;

  // Shared decode: button edges, current-entry end detection and the index
  // to load when (re)entering NOTE. dur=0 encodes 8 beats.
  always_comb begin
    play_e     = bus.play & ~play_q;
    stop_e     = bus.stop & ~stop_q;
    cur_entry  = lookup(note_idx_q);
    dur_beats  = {(cur_entry.dur == 3'd0), cur_entry.dur};
    note_done  = (state_q == NOTE) && (cyc_q == TICK_LAST) &&
                 ((beat_q + 4'd1) == dur_beats);
    gap_done   = (state_q == GAP) && (cyc_q == GAP_LAST);
    song_end   = cur_entry.last | (note_idx_q == IDX_LAST);
    if (state_q == IDLE || song_end) begin
      load_idx = '0;
    end else begin
      load_idx = note_idx_q + 1'b1;
    end
    load_entry = lookup(load_idx);
  end

  // State and output registers.
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      beat_q     <= '0;
      note_idx_q <= '0;
      sel_q      <= '0;
      flat_q     <= 1'b0;
      octave_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // Start high so a button held through reset is not seen as an edge.
      play_q     <= 1'b1;
      stop_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      beat_q     <= beat_d;
      note_idx_q <= note_idx_d;
      sel_q      <= sel_d;
      flat_q     <= flat_d;
      octave_q   <= octave_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      play_q     <= bus.play;
      stop_q     <= bus.stop;
    end
  end

  // Next-state logic. stop always takes priority over start and song end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (play_e && !stop_e) state_d = NOTE;
      NOTE: begin
        if (stop_e)         state_d = IDLE;
        else if (note_done) state_d = GAP;
      end
      GAP: begin
        if (stop_e) begin
          state_d = IDLE;
        end else if (gap_done) begin
`ifdef MELODY_LOOP_EN
          state_d = NOTE;
`else
          state_d = song_end ? IDLE : NOTE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and counter logic. Counters clear on every state change; note
  // outputs load on NOTE entry, blank on GAP entry, clear fully in IDLE.
  always_comb begin
    cyc_d      = cyc_q;
    beat_d     = beat_q;
    note_idx_d = note_idx_q;
    sel_d      = sel_q;
    flat_d     = flat_q;
    octave_d   = octave_q;
    busy_d     = (state_d != IDLE);
    done_d     = gap_done && song_end && !stop_e;

    if (state_d != state_q) begin
      cyc_d  = '0;
      beat_d = '0;
    end else if (state_q == NOTE) begin
      if (cyc_q == TICK_LAST) begin
        cyc_d  = '0;
        beat_d = beat_q + 4'd1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end else if (state_q == GAP) begin
      cyc_d = cyc_q + 1'b1;
    end

    case (state_d)
      IDLE: begin
        note_idx_d = '0;
        sel_d      = '0;
        flat_d     = 1'b0;
        octave_d   = 1'b0;
      end
      GAP: begin
        sel_d    = '0;
        flat_d   = 1'b0;
        octave_d = 1'b0;
      end
      NOTE: begin
        if (state_q != NOTE) begin
          note_idx_d = load_idx;
          sel_d      = note_sel(load_entry.note);
          // The buzzer has no flat tone for do and fa.
          flat_d     = load_entry.flat && (load_entry.note != 3'd1) &&
                       (load_entry.note != 3'd4);
          octave_d   = load_entry.octave;
        end
      end
      default: ;
    endcase
  end

  assign bus.sel      = sel_q;
  assign bus.flat     = flat_q;
  assign bus.octave   = octave_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = note_idx_q;

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player
//   Directed bench for melody_player with TICK_DIV=10, GAP_CYC=3.
//   dut_a plays the song table, dut_b the end-free diagnostic table.
module tb_melody_player;
  localparam int TICK  = 10;
  localparam int GAPC  = 3;
  localparam int IDX_W = 5;

  logic clk_1MHz = 1'b0;
  logic rst      = 1'b0;

  always #5 clk_1MHz = ~clk_1MHz;

  melody_player_if #(.IDX_W(IDX_W)) bus_a ();
  melody_player_if #(.IDX_W(IDX_W)) bus_b ();

  melody_player #(.TICK_DIV(TICK), .GAP_CYC(GAPC), .IDX_W(IDX_W), .TABLE_ID(0)) dut_a (
    .clk_1MHz(clk_1MHz),
    .rst(rst),
    .bus(bus_a)
  );

  melody_player #(.TICK_DIV(TICK), .GAP_CYC(GAPC), .IDX_W(IDX_W), .TABLE_ID(1)) dut_b (
    .clk_1MHz(clk_1MHz),
    .rst(rst),
    .bus(bus_b)
  );

  typedef struct {
    string            name;
    logic             play;
    logic             stop;
    int               steps;
    logic [6:0]       sel;
    logic             flat;
    logic             octave;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] idx;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[14];

  function automatic vec_t mk(input string name, input logic play, input logic stop,
                              input int steps, input logic [6:0] sel, input logic flat,
                              input logic octave, input logic busy, input logic done,
                              input int idx);
    vec_t v;
    v.name   = name;
    v.play   = play;
    v.stop   = stop;
    v.steps  = steps;
    v.sel    = sel;
    v.flat   = flat;
    v.octave = octave;
    v.busy   = busy;
    v.done   = done;
    v.idx    = IDX_W'(idx);
    return v;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic applyStimulus(input logic play, input logic stop, input int steps);
    bus_a.play = play;
    bus_a.stop = stop;
    repeat (steps) tick();
  endtask

  task automatic checkOutput(input string name, input logic [6:0] e_sel, input logic e_flat,
                             input logic e_oct, input logic e_busy, input logic e_done,
                             input logic [IDX_W-1:0] e_idx);
    total++;
    if (bus_a.sel !== e_sel || bus_a.flat !== e_flat || bus_a.octave !== e_oct ||
        bus_a.busy !== e_busy || bus_a.done !== e_done || bus_a.note_idx !== e_idx) begin
      bad++;
      $display("[TB] FAIL %s: got sel=%b flat=%b oct=%b busy=%b done=%b idx=%0d, want sel=%b flat=%b oct=%b busy=%b done=%b idx=%0d",
               name, bus_a.sel, bus_a.flat, bus_a.octave, bus_a.busy, bus_a.done, bus_a.note_idx,
               e_sel, e_flat, e_oct, e_busy, e_done, e_idx);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int done_step;

    // Song walk: entry0 do x2 beats, entry1 do (flat suppressed) x1,
    // entry2 high re flat x8 beats with end marker. Each record sets the
    // buttons, advances 'steps' clocks, then compares.
    vecs[0]  = mk("idle_after_reset", 0, 0, 1,  7'b0000000, 0, 0, 0, 0, 0);
    vecs[1]  = mk("e0_first_cycle",   1, 0, 1,  7'b1000000, 0, 0, 1, 0, 0);
    vecs[2]  = mk("e0_cycle20",       1, 0, 19, 7'b1000000, 0, 0, 1, 0, 0);
    vecs[3]  = mk("e0_gap_first",     0, 0, 1,  7'b0000000, 0, 0, 1, 0, 0);
    vecs[4]  = mk("e0_gap_last",      0, 0, 2,  7'b0000000, 0, 0, 1, 0, 0);
    vecs[5]  = mk("e1_do_flat_off",   0, 0, 1,  7'b1000000, 0, 0, 1, 0, 1);
    vecs[6]  = mk("e1_play_ignored",  1, 0, 9,  7'b1000000, 0, 0, 1, 0, 1);
    vecs[7]  = mk("e1_gap_first",     0, 0, 1,  7'b0000000, 0, 0, 1, 0, 1);
    vecs[8]  = mk("e2_re_flat_high",  0, 0, 3,  7'b0100000, 1, 1, 1, 0, 2);
    vecs[9]  = mk("e2_cycle80",       0, 0, 79, 7'b0100000, 1, 1, 1, 0, 2);
    vecs[10] = mk("e2_gap_first",     0, 0, 1,  7'b0000000, 0, 0, 1, 0, 2);
    vecs[11] = mk("e2_gap_last",      0, 0, 2,  7'b0000000, 0, 0, 1, 0, 2);
`ifdef MELODY_LOOP_EN
    vecs[12] = mk("end_done_loop",    0, 0, 1,  7'b1000000, 0, 0, 1, 1, 0);
    vecs[13] = mk("loop_replay",      0, 0, 1,  7'b1000000, 0, 0, 1, 0, 0);
`else
    vecs[12] = mk("end_done_pulse",   0, 0, 1,  7'b0000000, 0, 0, 0, 1, 0);
    vecs[13] = mk("end_done_cleared", 0, 0, 1,  7'b0000000, 0, 0, 0, 0, 0);
`endif

    bus_a.play = 1'b0;
    bus_a.stop = 1'b0;
    bus_b.play = 1'b0;
    bus_b.stop = 1'b0;
    rst        = 1'b0;
    repeat (3) tick();
    checkOutput("reset_state", 7'b0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].play, vecs[i].stop, vecs[i].steps);
      checkOutput(vecs[i].name, vecs[i].sel, vecs[i].flat, vecs[i].octave,
                  vecs[i].busy, vecs[i].done, vecs[i].idx);
    end

    // Make sure we are idle before the corner cases (stops a looping song).
    applyStimulus(0, 1, 1);
    checkOutput("stop_to_idle", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);

    // Stop edge five cycles into a note.
    applyStimulus(1, 0, 5);
    checkOutput("stop_pre_note", 7'b1000000, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("stop_mid_note", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5);
    checkOutput("stop_stays_idle", 7'b0, 0, 0, 0, 0, 0);

    // Play and stop edges together in IDLE: no start.
    applyStimulus(1, 1, 1);
    checkOutput("play_stop_same", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3);
    checkOutput("play_stop_held", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);

    // Asynchronous reset mid-note with play held through the release.
    applyStimulus(1, 0, 3);
    checkOutput("pre_reset_busy", 7'b1000000, 0, 0, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_now", 7'b0, 0, 0, 0, 0, 0);
    @(posedge clk_1MHz);
    #2;
    rst = 1'b1;
    applyStimulus(1, 0, 4);
    checkOutput("held_play_no_start", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("restart_after_reset", 7'b1000000, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("final_stop", 7'b0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);

    // End-free table: every entry is 10 + 3 cycles, so index 31 starts at
    // step 404 and done arrives at step 417.
    done_step  = 0;
    bus_b.play = 1'b1;
    for (int step = 1; step <= 600; step++) begin
      tick();
      if (step == 1) begin
        checkValue("b_first_sel", int'(bus_b.sel), int'(7'b0000001));
      end
      if (step == 404) begin
        checkValue("b_idx31", int'(bus_b.note_idx), 31);
        checkValue("b_idx31_sel", int'(bus_b.sel), int'(7'b0000100));
      end
      if (bus_b.done) begin
        done_step = step;
        break;
      end
    end
    checkValue("b_done_step", done_step, 417);
`ifdef MELODY_LOOP_EN
    checkValue("b_busy_at_done", int'(bus_b.busy), 1);
`else
    checkValue("b_busy_at_done", int'(bus_b.busy), 0);
`endif
    bus_b.play = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
